// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial add/subtract unit.
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_nibble_adder.sv
// Purely combinational 4-bit ripple adder built from four full adders,
// used as the single arithmetic stage of the serial unit.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module nibble_adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract that reuses one 4-bit adder stage, LSB nibble first,
// with a registered inter-nibble carry and valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for an operand pair; in_ready high
// RUN   | one nibble added per clock, idx selects the nibble
// DONE  | result held; out_valid high until out_ready
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               ovf_q;

    logic [NIB_W-1:0]   a_nib;
    logic [NIB_W-1:0]   b_nib;
    logic [NIB_W-1:0]   nib_sum;
    logic               nib_cout;
    logic               last;

    assign a_nib = a_q[idx*NIB_W +: NIB_W];
    assign b_nib = b_q[idx*NIB_W +: NIB_W];
    assign last  = (idx == IDX_W'(NIB - 1));

    nibble_adder u_stage (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last)      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // subtract folds into A + ~B + 1: invert B here, seed carry with in_sub
                        a_q   <= in_a;
                        b_q   <= in_b ^ {WIDTH{in_sub}};
                        carry <= in_sub;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum_q[idx*NIB_W +: NIB_W] <= nib_sum;
                    carry                     <= nib_cout;
                    if (last) begin
                        idx   <= '0;
                        ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                 (nib_sum[NIB_W-1] != a_q[WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = carry;
    assign out_ovf   = ovf_q;

endmodule
